// File: rtl/unit_clause_dispatch.sv
// unit_clause_dispatch: issues pending unit clauses one at a time in round-robin order
// and sends the clear-back request to the unit clause register once each has been propagated.
module unit_clause_dispatch #(
    parameter int CLAUSE_NUM = 8,
    parameter int IDX_W = (CLAUSE_NUM > 1) ? $clog2(CLAUSE_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CLAUSE_NUM-1:0] unit_clause,
    input  logic                  start,
    input  logic                  abort,
    output logic                  uc_valid,
    output logic [IDX_W-1:0]      uc_idx,
    input  logic                  uc_ready,
    input  logic                  prop_done,
    output logic                  rw_en,
    output logic [CLAUSE_NUM-1:0] delete_unit,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, CLEAR} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, uc_idx_n, off, pick;
    logic [IDX_W:0] sum;
    logic [2*CLAUSE_NUM-1:0] dbl;
    logic [CLAUSE_NUM-1:0] rot, delete_n;
    logic uc_valid_n, rw_en_n, done_n;
    // rotate so bit 0 is the pointer position; lowest set bit is the next clause
    assign dbl = {unit_clause, unit_clause} >> ptr;
    assign rot = dbl[CLAUSE_NUM-1:0];
    always_comb begin
        off = '0;
        for (int i = CLAUSE_NUM - 1; i >= 0; i--)
            if (rot[i]) off = IDX_W'(i);
    end
    assign sum  = {1'b0, ptr} + {1'b0, off};
    assign pick = (sum >= (IDX_W+1)'(CLAUSE_NUM)) ? IDX_W'(sum - (IDX_W+1)'(CLAUSE_NUM)) : IDX_W'(sum);
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        uc_valid_n = uc_valid;
        uc_idx_n   = uc_idx;
        rw_en_n    = 1'b0;
        delete_n   = '1;
        done_n     = 1'b0;
        if (abort) begin
            state_n    = IDLE;
            uc_valid_n = 1'b0;
        end else begin
            case (state)
                IDLE:  state_n = start ? SCAN : IDLE;
                SCAN: begin
                    state_n    = (unit_clause == '0) ? IDLE : ISSUE;
                    done_n     = (unit_clause == '0);
                    uc_valid_n = (unit_clause != '0);
                    uc_idx_n   = (unit_clause == '0) ? uc_idx : pick;
                end
                ISSUE: begin
                    state_n    = uc_ready ? WAIT : ISSUE;
                    uc_valid_n = !uc_ready;
                end
                WAIT: begin
                    state_n  = prop_done ? CLEAR : WAIT;
                    rw_en_n  = prop_done;
                    delete_n = prop_done ? ~(CLAUSE_NUM'(1) << uc_idx) : '1;
                end
                CLEAR: begin
                    state_n = SCAN;
                    ptr_n   = (uc_idx == IDX_W'(CLAUSE_NUM - 1)) ? '0 : uc_idx + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            uc_valid    <= 1'b0;
            uc_idx      <= '0;
            rw_en       <= 1'b0;
            delete_unit <= '1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            uc_valid    <= uc_valid_n;
            uc_idx      <= uc_idx_n;
            rw_en       <= rw_en_n;
            delete_unit <= delete_n;
            busy        <= (state_n != IDLE);
            done        <= done_n;
        end
    end
endmodule

// File: doc/unit_clause_dispatch.md
Name: unit_clause_dispatch

Overview:
- Reader/consumer for the unit clause register, the per-clause bitmask of pending unit clauses.
- During a BCP phase it scans the pending vector round-robin and issues one unit clause index at a time to the propagation engine over a valid/ready handshake.
- After propagation of that clause finishes, it generates the rw_en / delete_unit clear request back to the unit clause register.
- It signals done when no unit clauses remain.

Parameters:
- CLAUSE_NUM, 8, number of clauses; set from the global clause_num define.
- IDX_W, $clog2(CLAUSE_NUM) (minimum 1), width of the issued clause index.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- unit_clause  input  CLAUSE_NUM  current pending unit-clause vector from the unit clause register
- start  input  1  begin a dispatch run; sampled only in IDLE
- abort  input  1  conflict/backtrack; cancel the run immediately
- uc_valid  output  1  issued clause index is valid
- uc_idx  output  IDX_W  issued clause index
- uc_ready  input  1  propagation engine accepts uc_idx
- prop_done  input  1  propagation of the accepted clause is complete
- rw_en  output  1  one-cycle clear request to the unit clause register
- delete_unit  output  CLAUSE_NUM  AND-mask for the clear: 0 at the cleared index, 1 elsewhere
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse: run ended with an empty vector

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, round-robin pointer 0, uc_valid 0, uc_idx 0, rw_en 0, delete_unit all ones, busy 0, done 0. Reset mid-run abandons the run with no clear issued.
- FSM states: IDLE, SCAN, ISSUE, WAIT, CLEAR.
- IDLE:
  - start=1 → SCAN.
  - start in any other state is ignored.
- SCAN (one cycle):
  - unit_clause==0 → IDLE, with done=1 in the following cycle.
  - Otherwise select the first set bit at or above the pointer, wrapping past CLAUSE_NUM-1 to 0. Register it into uc_idx, set uc_valid=1, go to ISSUE.
- ISSUE:
  - Hold uc_valid=1 and a stable uc_idx until uc_ready=1.
  - Handshake cycle: uc_valid=1 and uc_ready=1. On that cycle go to WAIT; uc_valid drops in the next cycle.
  - prop_done is ignored in ISSUE.
- WAIT:
  - prop_done=1 → CLEAR.
  - uc_ready is ignored in WAIT.
- CLEAR (one cycle):
  - rw_en=1 and delete_unit=~(1<<uc_idx).
  - Pointer becomes uc_idx+1, wrapping CLAUSE_NUM-1 → 0.
  - Next state: SCAN.
  - The register applies the clear at the end of CLEAR, so SCAN sees the updated vector.
- Lost clears:
  - If a simultaneous register write (w_en) overrides the clear, the index stays set. It may be re-dispatched later; this is acceptable behaviour.
- delete_unit returns to all ones whenever rw_en=0.
- abort:
  - Highest priority in every state, including over start.
  - Next cycle: IDLE, uc_valid=0, rw_en=0, done=0.
  - No clear is issued for the in-flight clause. The pointer is retained.
- unit_clause is sampled only in SCAN. Changes in other states have no effect until the next SCAN.
- Throughput: minimum 4 cycles per clause (SCAN, ISSUE, WAIT, CLEAR) with uc_ready and prop_done held high.

Test Plan:
1. Reset: assert rst asynchronously mid-ISSUE → uc_valid=0, rw_en=0, delete_unit=8'hFF, busy=0 with no clock edge needed; state IDLE.
2. Basic run: unit_clause=8'h24, start pulse, uc_ready=1, prop_done 2 cycles after each handshake, with the bench model clearing bits on rw_en.
   - Expect uc_idx=2 with delete_unit=8'hFB, then uc_idx=5 with delete_unit=8'hDF.
   - Then one done pulse; busy falls.
3. Empty start: unit_clause=0, start at cycle 0 → SCAN at cycle 1, done=1 at cycle 2 only, no uc_valid, no rw_en.
4. Backpressure: unit_clause=8'h10, uc_ready low for 5 cycles → uc_valid=1 and uc_idx=4 held stable all 5 cycles. Handshake on cycle 6, exactly one rw_en later.
5. Wrap: unit_clause=8'h81 from pointer 0.
   - Issues 0 (pointer→1), then 7 (pointer wraps to 0).
   - Then done.
   - Delete masks 8'hFE, 8'h7F.
6. Abort: abort asserted in WAIT with idx 3 in flight → IDLE next cycle, no rw_en, vector unchanged. A restart then re-issues idx 3.
